// File: rtl/mac_seq_if.sv
// Stream-side handshake bundle of one MAC lane sequencer:
// operand beats in on the slave side, result qualifiers out on the master side.
interface mac_seq_if #(
    parameter int WL = 8,
    parameter int WI = 16
);
    logic [WL-1:0] cfg_len;
    logic          s_valid;
    logic          s_ready;
    logic          m_valid;
    logic          m_ready;
    logic [WI-1:0] m_idx;

    modport master (
        output cfg_len, s_valid, m_ready,
        input  s_ready, m_valid, m_idx
    );

    modport slave (
        input  cfg_len, s_valid, m_ready,
        output s_ready, m_valid, m_idx
    );
endinterface

// File: rtl/mac_seq.sv
// Sequencer for one mul -> acc MAC lane: splits accepted beats into dot products
// of cfg_len beats and aligns the accumulator qualifiers and result valid.
module mac_seq #(
    parameter int LM = 1,
    parameter int LA = 1,
    parameter int WL = 8,
    parameter int WI = 16
) (
    input  logic     clk,
    input  logic     rst,
    mac_seq_if.slave bus,
    output logic     mac_rstn,
    output logic     en,
    output logic     x_valid,
    output logic     first,
    output logic     busy
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [WL-1:0] cnt, cnt_nxt;
    logic [WL-1:0] len, len_nxt, len_new;
    logic          accept;
    logic          f0, l0;
    logic [LM-1:0] v_pipe, f_pipe, l_pipe;
    logic [LA-1:0] m_pipe;
    logic [WI-1:0] idx;

    // A held result freezes the whole lane; nothing downstream can buffer it.
    assign mac_rstn    = ~rst;
    assign en          = ~rst & ~(bus.m_valid & ~bus.m_ready);
    assign bus.s_ready = en;
    assign accept      = bus.s_valid & en;
    assign len_new     = (bus.cfg_len == '0) ? WL'(1) : bus.cfg_len;

    assign x_valid     = v_pipe[LM-1];
    assign first       = f_pipe[LM-1];
    assign bus.m_valid = m_pipe[LA-1];
    assign bus.m_idx   = idx;
    assign busy        = (cnt != '0) | accept | (|v_pipe) | (|m_pipe);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len;
        f0        = 1'b0;
        l0        = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    len_nxt = len_new;
                    f0      = 1'b1;
                    if (len_new == WL'(1)) begin
                        l0 = 1'b1;
                    end else begin
                        cnt_nxt   = WL'(1);
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (cnt == len - WL'(1)) begin
                        l0        = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + WL'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            len    <= WL'(1);
            v_pipe <= '0;
            f_pipe <= '0;
            l_pipe <= '0;
            m_pipe <= '0;
            idx    <= '0;
        end else if (en) begin
            cnt       <= cnt_nxt;
            len       <= len_nxt;
            v_pipe[0] <= accept;
            f_pipe[0] <= f0;
            l_pipe[0] <= accept & l0;
            for (int i = 1; i < LM; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                f_pipe[i] <= f_pipe[i-1];
                l_pipe[i] <= l_pipe[i-1];
            end
            // Last-beat tag leaves the mul stage and walks the acc delay line.
            m_pipe[0] <= l_pipe[LM-1];
            for (int i = 1; i < LA; i++) begin
                m_pipe[i] <= m_pipe[i-1];
            end
            if (bus.m_valid && bus.m_ready) begin
                idx <= idx + WI'(1);
            end
        end
    end
endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: lane 0 uses LM=1/LA=1, lane 1 uses LM=3/LA=2.
// An enabled-cycle event schedule predicts every output each cycle.
module tb_mac_seq;
    localparam int WL  = 8;
    localparam int WI  = 16;
    localparam int LM0 = 1;
    localparam int LA0 = 1;
    localparam int LM1 = 3;
    localparam int LA1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    rst_t;
    logic [1:0]    s_valid_t;
    logic [1:0]    m_ready_t;
    logic [WL-1:0] cfg_t [2];
    int            prod_t [2];

    logic [1:0]    mrstn_o, en_o, xv_o, first_o, busy_o, srdy_o, mv_o;
    logic [WI-1:0] idx_o [2];

    mac_seq_if #(.WL(WL), .WI(WI)) bus_a ();
    mac_seq_if #(.WL(WL), .WI(WI)) bus_b ();

    assign bus_a.cfg_len = cfg_t[0];
    assign bus_a.s_valid = s_valid_t[0];
    assign bus_a.m_ready = m_ready_t[0];
    assign bus_b.cfg_len = cfg_t[1];
    assign bus_b.s_valid = s_valid_t[1];
    assign bus_b.m_ready = m_ready_t[1];
    assign srdy_o[0] = bus_a.s_ready;
    assign srdy_o[1] = bus_b.s_ready;
    assign mv_o[0]   = bus_a.m_valid;
    assign mv_o[1]   = bus_b.m_valid;
    assign idx_o[0]  = bus_a.m_idx;
    assign idx_o[1]  = bus_b.m_idx;

    mac_seq #(.LM(LM0), .LA(LA0), .WL(WL), .WI(WI)) dut_a (
        .clk(clk), .rst(rst_t[0]), .bus(bus_a), .mac_rstn(mrstn_o[0]), .en(en_o[0]),
        .x_valid(xv_o[0]), .first(first_o[0]), .busy(busy_o[0])
    );
    mac_seq #(.LM(LM1), .LA(LA1), .WL(WL), .WI(WI)) dut_b (
        .clk(clk), .rst(rst_t[1]), .bus(bus_b), .mac_rstn(mrstn_o[1]), .en(en_o[1]),
        .x_valid(xv_o[1]), .first(first_o[1]), .busy(busy_o[1])
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0, last_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s lane%0d cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
        end
    endtask

    function automatic int lm(input int k);
        return (k == 0) ? LM0 : LM1;
    endfunction

    function automatic int la(input int k);
        return (k == 0) ? LA0 : LA1;
    endfunction

    // Model: events scheduled by enabled-cycle number in 16-entry rings.
    typedef struct {int cyc; int idx; int sum;} res_t;
    bit [15:0] xv_q [2];
    bit [15:0] fi_q [2];
    bit [15:0] mv_q [2];
    int        mv_sum [2][16];
    int        ecount [2], pos [2], vlen [2], vsum [2], midx [2];
    int        first_cnt [2], first_last [2], en_low_cnt [2];
    res_t      res_a [$];
    res_t      res_b [$];

    always @(negedge clk) begin : compare
        int slot, nxt;
        bit exp_mv, exp_en, acc, exp_busy;
        res_t r;
        for (int k = 0; k < 2; k++) begin
            if (rst_t[k]) begin
                check("en_rst", k, en_o[k], 0);
                check("s_ready_rst", k, srdy_o[k], 0);
                check("mac_rstn_rst", k, mrstn_o[k], 0);
                xv_q[k] = '0; fi_q[k] = '0; mv_q[k] = '0;
                pos[k] = 0; midx[k] = 0; ecount[k] = 0;
            end else begin
                slot     = ecount[k] % 16;
                exp_mv   = mv_q[k][slot];
                exp_en   = !(exp_mv && !m_ready_t[k]);
                acc      = s_valid_t[k] && exp_en;
                exp_busy = acc || (pos[k] != 0) || (|xv_q[k]) || (|mv_q[k]);
                check("mac_rstn", k, mrstn_o[k], 1);
                check("en", k, en_o[k], exp_en);
                check("s_ready", k, srdy_o[k], exp_en);
                check("x_valid", k, xv_o[k], xv_q[k][slot]);
                check("first", k, first_o[k], fi_q[k][slot]);
                check("m_valid", k, mv_o[k], exp_mv);
                check("m_idx", k, idx_o[k], midx[k]);
                check("busy", k, busy_o[k], exp_busy);
                if (first_o[k]) begin
                    first_cnt[k]++;
                    first_last[k] = cyc;
                end
                if (!en_o[k]) en_low_cnt[k]++;
                if (mv_o[k] && m_ready_t[k]) begin
                    r = '{cyc, int'(idx_o[k]), mv_sum[k][slot]};
                    if (k == 0) res_a.push_back(r);
                    else        res_b.push_back(r);
                end
                if (exp_en) begin
                    if (exp_mv && m_ready_t[k]) midx[k] = (midx[k] + 1) % 65536;
                    xv_q[k][slot] = 1'b0;
                    fi_q[k][slot] = 1'b0;
                    mv_q[k][slot] = 1'b0;
                    if (acc) begin
                        if (pos[k] == 0) begin
                            vlen[k] = (cfg_t[k] == 0) ? 1 : int'(cfg_t[k]);
                            vsum[k] = 0;
                        end
                        vsum[k] += prod_t[k];
                        nxt = (ecount[k] + lm(k)) % 16;
                        xv_q[k][nxt] = 1'b1;
                        fi_q[k][nxt] = (pos[k] == 0);
                        pos[k]++;
                        if (pos[k] == vlen[k]) begin
                            nxt = (ecount[k] + lm(k) + la(k)) % 16;
                            mv_q[k][nxt]   = 1'b1;
                            mv_sum[k][nxt] = vsum[k];
                            pos[k] = 0;
                        end
                    end
                    ecount[k]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k, input int n);
        s_valid_t[k] = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_t = 2'b11; s_valid_t = 2'b00; m_ready_t = 2'b11;
        tick();
        rst_t = 2'b00;
    endtask

    task automatic clear_logs();
        res_a.delete(); res_b.delete();
        first_cnt = '{0, 0}; en_low_cnt = '{0, 0};
        t0 = cyc;
    endtask

    // Presents one beat and holds it until the lane takes it.
    task automatic send(input int k, input int p);
        bit done;
        done = 1'b0;
        s_valid_t[k] = 1'b1;
        prod_t[k] = p;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (srdy_o[k]) begin
                done = 1'b1;
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", k, 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        rst_t = 2'b11; s_valid_t = 2'b00; m_ready_t = 2'b11;
        cfg_t[0] = '0; cfg_t[1] = '0; prod_t = '{0, 0};
        repeat (2) tick();
        rst_t = 2'b00;

        // cfg_len=4, products 1..4
        cfg_t[0] = 8'd4;
        clear_logs();
        send(0, 1); send(0, 2); send(0, 3); send(0, 4);
        idle(0, 4);
        check("s1_count", 0, res_a.size(), 1);
        if (res_a.size() > 0) begin
            check("s1_cycle", 0, res_a[0].cyc - t0, 5);
            check("s1_idx", 0, res_a[0].idx, 0);
            check("s1_sum", 0, res_a[0].sum, 10);
        end
        check("s1_first_cnt", 0, first_cnt[0], 1);
        check("s1_first_cyc", 0, first_last[0] - t0, 1);

        // back-to-back vectors of 2
        do_reset();
        cfg_t[0] = 8'd2;
        clear_logs();
        send(0, 5); send(0, 6); send(0, 7); send(0, 8);
        idle(0, 4);
        check("s2_count", 0, res_a.size(), 2);
        if (res_a.size() > 1) begin
            check("s2_sum0", 0, res_a[0].sum, 11);
            check("s2_sum1", 0, res_a[1].sum, 15);
            check("s2_idx0", 0, res_a[0].idx, 0);
            check("s2_idx1", 0, res_a[1].idx, 1);
            check("s2_spacing", 0, res_a[1].cyc - res_a[0].cyc, 2);
        end

        // result backpressure for 3 cycles
        do_reset();
        cfg_t[0] = 8'd2;
        clear_logs();
        m_ready_t[0] = 1'b0;
        fork
            begin
                send(0, 1); send(0, 2); send(0, 3); send(0, 4);
                idle(0, 6);
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(negedge clk);
                    if (mv_o[0]) seen = 1'b1;
                end
                if (!seen) check("s3_mvalid_timeout", 0, 0, 1);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                m_ready_t[0] = 1'b1;
            end
        join
        check("s3_en_low", 0, en_low_cnt[0], 3);
        check("s3_count", 0, res_a.size(), 2);
        if (res_a.size() > 1) begin
            check("s3_xfer_cyc", 0, res_a[0].cyc - t0, 6);
            check("s3_sum0", 0, res_a[0].sum, 3);
            check("s3_idx0", 0, res_a[0].idx, 0);
            check("s3_sum1", 0, res_a[1].sum, 7);
            check("s3_idx1", 0, res_a[1].idx, 1);
        end

        // cfg_len=0 behaves as 1
        do_reset();
        cfg_t[0] = 8'd0;
        clear_logs();
        send(0, 2); send(0, 3); send(0, 4);
        idle(0, 4);
        check("s4_count", 0, res_a.size(), 3);
        for (int i = 0; i < res_a.size() && i < 3; i++) begin
            check("s4_sum", 0, res_a[i].sum, i + 2);
            check("s4_idx", 0, res_a[i].idx, i);
        end
        check("s4_first_cnt", 0, first_cnt[0], 3);

        // reset mid-vector
        do_reset();
        cfg_t[0] = 8'd4;
        clear_logs();
        send(0, 9); send(0, 9);
        s_valid_t[0] = 1'b0;
        rst_t[0] = 1'b1;
        tick();
        rst_t[0] = 1'b0;
        idle(0, 8);
        check("s5_no_result", 0, res_a.size(), 0);
        send(0, 1); send(0, 1); send(0, 1); send(0, 1);
        idle(0, 4);
        check("s5_count", 0, res_a.size(), 1);
        if (res_a.size() > 0) begin
            check("s5_sum", 0, res_a[0].sum, 4);
            check("s5_idx", 0, res_a[0].idx, 0);
        end

        // LM=3, LA=2 lane with random input gaps
        cfg_t[1] = 8'd3;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            send(1, 4 + i);
            s_valid_t[1] = 1'b0;
            if (i < 2) repeat ($urandom_range(0, 2)) tick();
        end
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (mv_o[1]) begin
                seen = 1'b1;
                check("s6_latency", 1, cyc - last_acc, 5);
                check("s6_busy_at_xfer", 1, busy_o[1], 1);
                check("s6_idx", 1, idx_o[1], 0);
            end
        end
        if (!seen) check("s6_mvalid_timeout", 1, 0, 1);
        @(negedge clk);
        check("s6_busy_after", 1, busy_o[1], 0);
        check("s6_count", 1, res_b.size(), 1);
        if (res_b.size() > 0) check("s6_sum", 1, res_b[0].sum, 15);
        idle(1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
